// File: rtl/soc_pkg.sv
// Shared SoC definitions for the UART peripheral: register offsets, STATUS bit
// positions, serial FSM state encodings and the divisor clamp helper.
package soc_pkg;

    localparam logic [3:0] UART_TXDATA  = 4'h0;
    localparam logic [3:0] UART_STATUS  = 4'h4;
    localparam logic [3:0] UART_RXDATA  = 4'h8;
    localparam logic [3:0] UART_DIVISOR = 4'hC;

    localparam int STS_TX_FULL   = 0;
    localparam int STS_TX_EMPTY  = 1;
    localparam int STS_TX_BUSY   = 2;
    localparam int STS_RX_VALID  = 3;
    localparam int STS_OVERRUN   = 4;
    localparam int STS_FRAME_ERR = 5;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [15:0] MIN_DIVISOR = 16'd4;

    // The RX mid-bit sampler needs divisor/2 of at least two clocks.
    function automatic logic [15:0] clamp_divisor(input logic [15:0] value);
        return (value < MIN_DIVISOR) ? MIN_DIVISOR : value;
    endfunction

endpackage

// File: rtl/mmu_uart_if.sv
// Device-side bus between the MMU and the UART: held enables, one-cycle
// mem_ready completion pulse with read data.
interface mmu_uart_if;
    logic        read_enable;
    logic        write_enable;
    logic [3:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mem_ready;

    modport master (
        output read_enable, write_enable, address, data_in,
        input  data_out, mem_ready
    );

    modport slave (
        input  read_enable, write_enable, address, data_in,
        output data_out, mem_ready
    );
endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word fall-through read data; extra pointer MSB tells
// full from empty when the index bits match.
module uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // A push into a full FIFO is only taken when a pop frees the slot that cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mmu_uart.sv
// Memory-mapped UART: bus register decode, TX shifter fed by a byte FIFO,
// and an RX mid-bit sampler with a single holding register.
module mmu_uart
    import soc_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int DEFAULT_DIVISOR = 868
) (
    input  logic      clk,
    input  logic      reset,
    mmu_uart_if.slave bus,
    output logic      uart_tx,
    input  logic      uart_rx
);

    logic [3:0]  reg_sel;
    logic        accept;
    logic        wr_acc;
    logic        rd_acc;
    logic        tx_push;
    logic        status_wr;
    logic        rx_read;
    logic        ready_q;
    logic [31:0] data_q;
    logic [31:0] rdata;
    logic [31:0] status_word;
    logic [15:0] divisor;

    logic        tx_full;
    logic        tx_empty;
    logic        tx_busy;
    logic        tx_pop;
    logic [7:0]  fifo_data;
    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [15:0] tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_line;
    logic        tx_bit_end;

    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [15:0] rx_div;
    logic [15:0] rx_half;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_bit_end;
    logic        rx_stop_sample;
    logic        rx_good;
    logic        rx_bad;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_overrun;
    logic        rx_frame_err;

    logic        unused_bits;

    assign unused_bits = &{1'b0, bus.address[1:0], bus.data_in[31:16]};

    // mem_ready gates acceptance, so enables still held in the response cycle are ignored.
    assign reg_sel   = {bus.address[3:2], 2'b00};
    assign accept    = (bus.read_enable || bus.write_enable) && !ready_q;
    assign wr_acc    = accept && bus.write_enable;
    assign rd_acc    = accept && !bus.write_enable;
    assign tx_push   = wr_acc && (reg_sel == UART_TXDATA);
    assign status_wr = wr_acc && (reg_sel == UART_STATUS);
    assign rx_read   = rd_acc && (reg_sel == UART_RXDATA);

    assign bus.mem_ready = ready_q;
    assign bus.data_out  = data_q;

    assign tx_busy = !tx_empty || (tx_state != TX_IDLE);

    always_comb begin
        status_word                = '0;
        status_word[STS_TX_FULL]   = tx_full;
        status_word[STS_TX_EMPTY]  = tx_empty;
        status_word[STS_TX_BUSY]   = tx_busy;
        status_word[STS_RX_VALID]  = rx_valid;
        status_word[STS_OVERRUN]   = rx_overrun;
        status_word[STS_FRAME_ERR] = rx_frame_err;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            UART_STATUS:  rdata = status_word;
            UART_RXDATA:  rdata = {rx_valid, 23'd0, rx_byte};
            UART_DIVISOR: rdata = {16'd0, divisor};
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            data_q  <= '0;
            divisor <= 16'(DEFAULT_DIVISOR);
        end else begin
            ready_q <= accept;
            data_q  <= rd_acc ? rdata : '0;
            if (wr_acc && (reg_sel == UART_DIVISOR)) begin
                divisor <= clamp_divisor(bus.data_in[15:0]);
            end
        end
    end

    uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (bus.data_in[7:0]),
        .pop       (tx_pop),
        .pop_data  (fifo_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // Each bit re-latches the divisor, so a divisor write lands at the next bit boundary.
    assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
    assign tx_pop     = !tx_empty &&
                        ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));
    assign uart_tx    = tx_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= 16'(DEFAULT_DIVISOR);
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            if (!tx_empty) begin
                tx_state <= TX_START;
                tx_shift <= fifo_data;
                tx_cnt   <= '0;
                tx_div   <= divisor;
                tx_line  <= 1'b0;
            end
        end else if (tx_bit_end) begin
            tx_cnt <= '0;
            tx_div <= divisor;
            case (tx_state)
                TX_START: begin
                    tx_state <= TX_DATA;
                    tx_bit   <= '0;
                    tx_line  <= tx_shift[0];
                end
                TX_DATA: begin
                    if (tx_bit == 3'd7) begin
                        tx_state <= TX_STOP;
                        tx_line  <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_line  <= tx_shift[1];
                    end
                end
                default: begin
                    if (!tx_empty) begin
                        tx_state <= TX_START;
                        tx_shift <= fifo_data;
                        tx_line  <= 1'b0;
                    end else begin
                        tx_state <= TX_IDLE;
                        tx_line  <= 1'b1;
                    end
                end
            endcase
        end else begin
            tx_cnt <= tx_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_half        = rx_div >> 1;
    assign rx_bit_end     = (rx_cnt == rx_div - 16'd1);
    assign rx_stop_sample = (rx_state == RX_STOP) && rx_bit_end;
    assign rx_good        = rx_stop_sample && rx_s2;
    assign rx_bad         = rx_stop_sample && !rx_s2;

    // A start edge still high at the half-bit point is treated as a glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= 16'(DEFAULT_DIVISOR);
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                        rx_div   <= divisor;
                    end
                end
                RX_START: begin
                    if (rx_cnt == rx_half - 16'd1) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_bit   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_div   <= divisor;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_bit_end) begin
                        rx_state <= RX_IDLE;
                        rx_cnt   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // A read in the same cycle as an arriving byte frees the holder, so no overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_good && (!rx_valid || rx_read)) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
            if (rx_good && rx_valid && !rx_read) begin
                rx_overrun <= 1'b1;
            end else if (status_wr && bus.data_in[STS_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end
            if (rx_bad) begin
                rx_frame_err <= 1'b1;
            end else if (status_wr && bus.data_in[STS_FRAME_ERR]) begin
                rx_frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmu_uart.sv
// Self-checking bench for mmu_uart: bus accesses, a serial TX monitor fed by an
// expected-byte queue, and RX frames driven onto uart_rx.
module tb_mmu_uart;
    import soc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic uart_tx;
    logic uart_rx;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int mon_div = 4;
    int last_start = -1;
    logic check_gap = 1'b0;
    logic mon_busy = 1'b0;

    logic [7:0]  tx_expect [$];
    logic [31:0] rx_expect [$];

    mmu_uart_if bus();

    mmu_uart #(
        .FIFO_DEPTH      (8),
        .DEFAULT_DIVISOR (868)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // One bus access: drive at a negedge, wait (bounded) for the mem_ready pulse.
    task automatic applyStimulus(input logic re, input logic we, input logic [3:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata);
        logic seen;
        seen = 1'b0;
        rdata = '0;
        @(negedge clk);
        bus.read_enable  = re;
        bus.write_enable = we;
        bus.address      = addr;
        bus.data_in      = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_ready) begin
                rdata = bus.data_out;
                seen = 1'b1;
                break;
            end
        end
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
        if (!seen) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        applyStimulus(1'b0, 1'b1, addr, wdata, dummy);
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] rdata);
        applyStimulus(1'b1, 1'b0, addr, 32'd0, rdata);
    endtask

    task automatic check_status(input string tag, input logic [31:0] expected);
        logic [31:0] value;
        bus_read(UART_STATUS, value);
        checkOutput(tag, value, expected);
    endtask

    task automatic wait_tx_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_expect.size() == 0 && !mon_busy) break;
        end
        checkOutput("tx_drained", 32'(tx_expect.size()), 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] value, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, value, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = frame[i];
            repeat (mon_div - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Serial monitor: samples each bit mid-way and scores against the queue.
    initial begin : tx_monitor
        logic prev;
        logic [7:0] value;
        logic stop_bit;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                if (check_gap && last_start >= 0)
                    checkOutput("tx_gap", 32'(cycle - last_start), 32'(10 * mon_div));
                last_start = cycle;
                repeat (mon_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    value[i] = uart_tx;
                end
                repeat (mon_div) @(negedge clk);
                stop_bit = uart_tx;
                checkOutput("tx_stop", {31'd0, stop_bit}, 32'd1);
                if (tx_expect.size() == 0) begin
                    checkOutput("tx_unexpected", {24'd0, value}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("tx_byte", {24'd0, value}, {24'd0, tx_expect.pop_front()});
                end
                mon_busy = 1'b0;
            end
            prev = uart_tx;
        end
    end

    initial begin : main
        logic [31:0] value;
        reset = 1'b1;
        uart_rx = 1'b1;
        bus.read_enable = 1'b0;
        bus.write_enable = 1'b0;
        bus.address = '0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset values");
        checkOutput("reset_tx", {31'd0, uart_tx}, 32'd1);
        check_status("reset_status", 32'h0000_0002);
        bus_read(UART_DIVISOR, value);
        checkOutput("reset_divisor", value, 32'd868);

        $display("[TB] single byte 0x55 at divisor 4");
        bus_write(UART_DIVISOR, 32'd4);
        tx_expect.push_back(8'h55);
        bus_write(UART_TXDATA, 32'h55);
        repeat (16) @(negedge clk);
        check_status("tx_busy_mid", 32'h0000_0006);
        wait_tx_drain(200);
        repeat (10) @(negedge clk);
        check_status("tx_idle_after", 32'h0000_0002);

        $display("[TB] burst of 11 writes");
        check_gap = 1'b1;
        last_start = -1;
        for (int i = 0; i < 11; i++) begin
            if (i < 9) tx_expect.push_back(8'(8'h10 + i));
            bus_write(UART_TXDATA, 32'(8'h10 + i));
        end
        check_status("burst_full", 32'h0000_0005);
        wait_tx_drain(1000);
        check_gap = 1'b0;
        repeat (10) @(negedge clk);
        check_status("burst_done", 32'h0000_0002);

        $display("[TB] rx frame 0xA3");
        rx_expect.push_back(32'h8000_00A3);
        send_rx(8'hA3, 1'b1);
        check_status("rx_valid_set", 32'h0000_000A);
        bus_read(UART_RXDATA, value);
        checkOutput("rx_a3", value, rx_expect.pop_front());
        check_status("rx_valid_clr", 32'h0000_0002);

        $display("[TB] rx overrun");
        rx_expect.push_back(32'h8000_0011);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check_status("overrun_set", 32'h0000_001A);
        bus_read(UART_RXDATA, value);
        checkOutput("rx_keep_old", value, rx_expect.pop_front());
        check_status("overrun_kept", 32'h0000_0012);
        bus_write(UART_STATUS, 32'h10);
        check_status("overrun_clr", 32'h0000_0002);

        $display("[TB] rx frame error and glitch");
        send_rx(8'h5A, 1'b0);
        check_status("frame_err_set", 32'h0000_0022);
        bus_write(UART_STATUS, 32'h20);
        check_status("frame_err_clr", 32'h0000_0002);
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check_status("glitch_ignored", 32'h0000_0002);

        $display("[TB] both enables and divisor clamp");
        tx_expect.push_back(8'h41);
        applyStimulus(1'b1, 1'b1, UART_TXDATA, 32'h41, value);
        checkOutput("both_en_dout", value, 32'd0);
        wait_tx_drain(200);
        bus_write(UART_DIVISOR, 32'd2);
        bus_read(UART_DIVISOR, value);
        checkOutput("divisor_clamp", value, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
